// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: entry layout, funct3 encodings, lane helpers.
// Purely declarative; no logic lives here.
package store_buffer_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int SB_DEPTH_DEFAULT = 4;

  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            funct3;
    logic [3:0]            be;
  } sb_entry_t;

  function automatic logic [DATA_WIDTH-1:0] be_to_bits(input logic [3:0] be);
    logic [DATA_WIDTH-1:0] bits;
    bits = '0;
    for (int b = 0; b < 4; b++) begin
      bits[8*b +: 8] = {8{be[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/store_buffer_mask_gen.sv
// Byte-enable generator: funct3 size + addr[1:0] -> 4-bit lane mask, misalign and legality flags.
// Combinational; the mask is forced to zero for misaligned or illegal accesses so it never matches.
module sb_mask_gen #(
  parameter bit IS_STORE = 1'b1
) (
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misalign,
  output logic       legal
);

  always_comb begin
    be       = '0;
    misalign = 1'b0;
    // Stores have no unsigned variants, so bit 2 set is an unknown store encoding.
    legal    = (funct3[1:0] != 2'b11) && !(IS_STORE && funct3[2]);
    case (funct3[1:0])
      2'b00: be = 4'b0001 << addr_lo;
      2'b01: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
      end
      default: be = '0;
    endcase
    if (misalign || !legal) be = '0;
  end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer in front of a single-port data memory; drains one store per load-free cycle (store visible to memory 1 cycle after acceptance).
// Backpressure: st_ready_o drops when full; loads hitting a buffered word are forwarded or stalled (SB_FWD_EN enables forwarding).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        st_valid_i,
  output logic                        st_ready_o,
  input  logic [DATA_WIDTH-1:0]       st_addr_i,
  input  logic [DATA_WIDTH-1:0]       st_data_i,
  input  logic [2:0]                  st_funct3_i,
  output logic                        st_misalign_o,
  input  logic                        ld_valid_i,
  input  logic [DATA_WIDTH-1:0]       ld_addr_i,
  input  logic [2:0]                  ld_funct3_i,
  output logic                        fwd_hit_o,
  output logic [DATA_WIDTH-1:0]       fwd_data_o,
  output logic                        ld_stall_o,
  output logic                        mem_we_o,
  output logic [DATA_WIDTH-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]       mem_wr_data_o,
  output logic [2:0]                  mem_funct3_o,
  output logic                        empty_o,
  output logic [$clog2(SB_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          entries [SB_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               empty;
  logic               st_accept;
  logic [3:0]         st_be;
  logic               st_mis;
  logic               st_legal;
  logic [3:0]         ld_be;
  logic               ld_mis;
  logic               ld_legal;
  logic               found;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   idx;

  sb_mask_gen #(.IS_STORE(1'b1)) u_st_mask (
    .funct3   (st_funct3_i),
    .addr_lo  (st_addr_i[1:0]),
    .be       (st_be),
    .misalign (st_mis),
    .legal    (st_legal)
  );

  sb_mask_gen #(.IS_STORE(1'b0)) u_ld_mask (
    .funct3   (ld_funct3_i),
    .addr_lo  (ld_addr_i[1:0]),
    .be       (ld_be),
    .misalign (ld_mis),
    .legal    (ld_legal)
  );

  // Occupancy is taken from registered state only, so a same-cycle drain never frees a slot.
  assign full          = (count == CNT_W'(SB_DEPTH));
  assign empty         = (count == '0);
  assign st_ready_o    = !full;
  assign st_misalign_o = st_valid_i && st_legal && st_mis;
  assign st_accept     = st_valid_i && st_ready_o && st_legal && !st_mis;
  assign empty_o       = empty;
  assign count_o       = count;

  // Youngest-first search so the newest store to a word wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = tail - PTR_W'(i + 1);
      if (!found && (CNT_W'(i) < count) &&
          (entries[idx].addr[DATA_WIDTH-1:2] == ld_addr_i[DATA_WIDTH-1:2])
`ifdef SB_FWD_EN
          && ((entries[idx].be & ld_be) != 4'b0000)
`endif
         ) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

`ifdef SB_FWD_EN
  logic covered;
  logic unused_ld;
  assign covered    = ((entries[sel].be & ld_be) == ld_be);
  assign fwd_hit_o  = ld_valid_i && found && covered;
  assign ld_stall_o = ld_valid_i && found && !covered;
  assign fwd_data_o = fwd_hit_o ? (entries[sel].data & be_to_bits(ld_be)) : '0;
  assign unused_ld  = ^{ld_mis, ld_legal};
`else
  logic unused_ld;
  assign fwd_hit_o  = 1'b0;
  assign fwd_data_o = '0;
  assign ld_stall_o = ld_valid_i && found;
  assign unused_ld  = ^{ld_be, ld_mis, ld_legal, entries[sel].be};
`endif

  // A stalled load gives up the port so the conflicting entry can drain.
  assign mem_we_o      = !empty && (!ld_valid_i || ld_stall_o);
  assign mem_addr_o    = entries[head].addr;
  assign mem_wr_data_o = entries[head].data;
  assign mem_funct3_o  = entries[head].funct3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (st_accept) begin
        entries[tail] <= '{addr: st_addr_i, data: st_data_i, funct3: st_funct3_i, be: st_be};
        tail          <= tail + PTR_W'(1);
      end
      if (mem_we_o) begin
        head <= head + PTR_W'(1);
      end
      case ({st_accept, mem_we_o})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The pipeline should never present a store and a load together; behaviour stays defined if it does.
  assert property (@(posedge clk) disable iff (rst) !(st_valid_i && ld_valid_i))
    else $warning("store and load valid in the same cycle");

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: table-driven single-cycle vectors plus hand sequences, memory writes checked against a scoreboard queue.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [2:0]  st_funct3_i;
  logic        st_misalign_o;
  logic        ld_valid_i;
  logic [31:0] ld_addr_i;
  logic [2:0]  ld_funct3_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic        ld_stall_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [2:0]  mem_funct3_o;
  logic        empty_o;
  logic [2:0]  count_o;

  store_buffer #(.SB_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid_i    (st_valid_i),
    .st_ready_o    (st_ready_o),
    .st_addr_i     (st_addr_i),
    .st_data_i     (st_data_i),
    .st_funct3_i   (st_funct3_i),
    .st_misalign_o (st_misalign_o),
    .ld_valid_i    (ld_valid_i),
    .ld_addr_i     (ld_addr_i),
    .ld_funct3_i   (ld_funct3_i),
    .fwd_hit_o     (fwd_hit_o),
    .fwd_data_o    (fwd_data_o),
    .ld_stall_o    (ld_stall_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_funct3_o  (mem_funct3_o),
    .empty_o       (empty_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [2:0]  sf;
    logic        lv;
    logic [31:0] la;
    logic [2:0]  lf;
    logic        mis;
    logic        hit;
    logic [31:0] fwd;
    logic        stall;
    logic        we;
    int          cnt;
    logic        push;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every memory write must match the oldest outstanding accepted store.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && mem_we_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_write: unexpected write addr 0x%0h expected none", mem_addr_o);
      end else begin
        e = sb_q.pop_front();
        chk("mem_addr", mem_addr_o, e.addr);
        chk("mem_data", mem_wr_data_o, e.data);
        chk("mem_funct3", 32'(mem_funct3_o), 32'(e.f3));
      end
    end
  end

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                       input logic lv, input logic [31:0] la, input logic [2:0] lf);
    @(posedge clk);
    #1;
    st_valid_i  = sv;
    st_addr_i   = sa;
    st_data_i   = sd;
    st_funct3_i = sf;
    ld_valid_i  = lv;
    ld_addr_i   = la;
    ld_funct3_i = lf;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
  endtask

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                              input logic lv, input logic [31:0] la, input logic [2:0] lf,
                              input logic mis, input logic hit, input logic [31:0] fwd, input logic stall,
                              input logic we, input int cnt, input logic push);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.sf = sf;
    v.lv = lv; v.la = la; v.lf = lf;
    v.mis = mis; v.hit = hit; v.fwd = fwd; v.stall = stall;
    v.we = we; v.cnt = cnt; v.push = push;
    return v;
  endfunction

  initial begin
    wr_t w;
    rst = 1'b1;
    st_valid_i = 0; st_addr_i = 0; st_data_i = 0; st_funct3_i = 0;
    ld_valid_i = 0; ld_addr_i = 0; ld_funct3_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_ready", 32'(st_ready_o), 1);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_hit", 32'(fwd_hit_o), 0);
    chk("rst_stall", 32'(ld_stall_o), 0);
    chk("rst_misalign", 32'(st_misalign_o), 0);
    chk("rst_count", 32'(count_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h100, 32'hDEADBEEF, FUNCT3_SW, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h401, 32'h1234, FUNCT3_SH, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h102, 32'h5678, FUNCT3_SW, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h500, 32'h9999, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h200, 32'h11223344, FUNCT3_SW, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h300, FUNCT3_LW, 0, 0, 0, 0, 0, 1, 0));
`ifdef SB_FWD_EN
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h202, FUNCT3_LBU, 0, 1, 32'h00220000, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h200, FUNCT3_LHU, 0, 1, 32'h00003344, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`else
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h202, FUNCT3_LBU, 0, 0, 0, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h200, FUNCT3_LHU, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h300, 32'h000000AA, FUNCT3_SB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h300, FUNCT3_LW, 0, 0, 0, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h300, FUNCT3_LW, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h402, 32'hBEEF0000, FUNCT3_SH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef SB_FWD_EN
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h402, FUNCT3_LH, 0, 1, 32'hBEEF0000, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h400, FUNCT3_LB, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`else
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h402, FUNCT3_LH, 0, 0, 0, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h400, FUNCT3_LB, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vt[i]) begin
      if (vt[i].push) begin
        w.addr = vt[i].sa; w.data = vt[i].sd; w.f3 = vt[i].sf;
        sb_q.push_back(w);
      end
      drive(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].sf, vt[i].lv, vt[i].la, vt[i].lf);
      chk($sformatf("v%0d_misalign", i), 32'(st_misalign_o), 32'(vt[i].mis));
      chk($sformatf("v%0d_ready", i), 32'(st_ready_o), 1);
      chk($sformatf("v%0d_hit", i), 32'(fwd_hit_o), 32'(vt[i].hit));
      chk($sformatf("v%0d_fwd", i), fwd_data_o, vt[i].fwd);
      chk($sformatf("v%0d_stall", i), 32'(ld_stall_o), 32'(vt[i].stall));
      chk($sformatf("v%0d_we", i), 32'(mem_we_o), 32'(vt[i].we));
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vt[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty_o), 32'(vt[i].cnt == 0));
    end

    // Fill to capacity while a load holds the port, then drain in order.
    for (int k = 0; k < 4; k++) begin
      w.addr = 32'h600 + 32'(4 * k); w.data = 32'hA0000000 + 32'(k); w.f3 = FUNCT3_SW;
      sb_q.push_back(w);
      drive(1, w.addr, w.data, FUNCT3_SW, 1, 32'h900, FUNCT3_LW);
      chk($sformatf("fill%0d_count", k), 32'(count_o), 32'(k));
      chk($sformatf("fill%0d_we", k), 32'(mem_we_o), 0);
    end
    drive(1, 32'h610, 32'h00000BAD, FUNCT3_SW, 1, 32'h900, FUNCT3_LW);
    chk("full_count", 32'(count_o), 4);
    chk("full_ready", 32'(st_ready_o), 0);
    chk("full_we", 32'(mem_we_o), 0);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("drain%0d_count", k), 32'(count_o), 32'(4 - k));
      chk($sformatf("drain%0d_we", k), 32'(mem_we_o), 1);
    end
    idle();
    chk("drained_count", 32'(count_o), 0);
    chk("drained_empty", 32'(empty_o), 1);

    // Enqueue and drain in the same cycle leave occupancy unchanged.
    w.addr = 32'h700; w.data = 32'h07070707; w.f3 = FUNCT3_SW; sb_q.push_back(w);
    drive(1, w.addr, w.data, FUNCT3_SW, 0, 0, 0);
    chk("sim_a_count", 32'(count_o), 0);
    w.addr = 32'h704; w.data = 32'h07040704; w.f3 = FUNCT3_SW; sb_q.push_back(w);
    drive(1, w.addr, w.data, FUNCT3_SW, 0, 0, 0);
    chk("sim_b_count", 32'(count_o), 1);
    chk("sim_b_we", 32'(mem_we_o), 1);
    idle();
    chk("sim_c_count", 32'(count_o), 1);
    chk("sim_c_we", 32'(mem_we_o), 1);
    idle();
    chk("sim_d_count", 32'(count_o), 0);

    // Reset in the middle of a drain discards everything immediately.
    for (int k = 0; k < 3; k++) begin
      w.addr = 32'h800 + 32'(4 * k); w.data = 32'h80000000 + 32'(k); w.f3 = FUNCT3_SW;
      sb_q.push_back(w);
      drive(1, w.addr, w.data, FUNCT3_SW, 1, 32'hA00, FUNCT3_LW);
    end
    @(posedge clk);
    #1;
    st_valid_i = 0; ld_valid_i = 0;
    #1;
    chk("pre_rst_count", 32'(count_o), 3);
    chk("pre_rst_we", 32'(mem_we_o), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(mem_we_o), 0);
    chk("mid_rst_empty", 32'(empty_o), 1);
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_ready", 32'(st_ready_o), 1);
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      idle();
      chk("post_rst_we", 32'(mem_we_o), 0);
    end

    chk("sb_outstanding", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
